// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the valid/ready
// instruction stream toward decode.
//   master (fetch unit): drives mem_rd_addr, instr_valid, instr, instr_addr;
//                        receives mem_rd_data, instr_ready
//   slave  (mem/decode): the mirror image
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_addr;

  modport master (
    output mem_rd_addr,
    input  mem_rd_data,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_addr
  );

  modport slave (
    input  mem_rd_addr,
    output mem_rd_data,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit. After the loader raises prog_rdy and start is pulsed,
// walks addresses 0..n_instructions-1 through a 1-cycle synchronous instruction
// memory and streams each word to decode over valid/ready, buffering up to two
// words against backpressure. redirect jumps the pc and flushes everything older.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   prog_rdy          program loaded; low forces IDLE and drops all fetch state
//   n_instructions    number of valid words in memory
//   start             pulse: begin fetching at address 0 (IDLE or DONE)
//   redirect(_addr)   pulse: jump to redirect_addr (RUN only)
//   bus               master side of instr_fetch_unit_if (mem read + decode stream)
//   busy, done        state == RUN / state == DONE
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_rdy,
  input  logic [BYTE_WIDTH-1:0] n_instructions,
  input  logic                  start,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  instr_fetch_unit_if.master    bus,
  output logic                  busy,
  output logic                  done
);

  // Compare width wide enough for both the extended pc and the count.
  localparam int CW = (BYTE_WIDTH > ADDR_WIDTH + 1) ? BYTE_WIDTH : ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   pc;        // extra MSB marks "ran past the top of memory"
  entry_t [1:0]          fifo;      // fifo[0] is the head
  logic [1:0]            count;
  logic                  inflight;  // a read issued last cycle returns data now
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_epoch;
  logic                  epoch;

  logic [CW-1:0] pc_ext, n_ext;
  logic          pc_in_range;
  logic          running;
  logic          pop;
  logic          push;
  logic          issue;
  logic [1:0]    used;
  entry_t        new_entry;

  assign pc_ext = CW'(pc);
  assign n_ext  = CW'(n_instructions);
  // Once pc reaches 2^ADDR_WIDTH the fetch stops even if the count is larger,
  // so the address never wraps back to 0.
  assign pc_in_range = !pc[ADDR_WIDTH] && (pc_ext < n_ext);

  assign running = (state == RUN) && prog_rdy;
  assign pop     = (count != 2'd0) && bus.instr_ready;

  // Slots spoken for after this edge. A pop frees its slot on the same edge
  // the new read issues, which is what keeps one word per cycle flowing with
  // ready held high while still never overfilling the two entries.
  assign used  = count + {1'b0, inflight} - {1'b0, pop};
  assign issue = running && !redirect && pc_in_range && (used < 2'd2);

  // Returning word is kept only if no redirect happened since it was issued.
  assign push      = running && !redirect && inflight && (if_epoch == epoch);
  assign new_entry = '{addr: if_addr, data: bus.mem_rd_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      fifo     <= '0;
      count    <= '0;
      inflight <= 1'b0;
      if_addr  <= '0;
      if_epoch <= 1'b0;
      epoch    <= 1'b0;
    end else if (!prog_rdy) begin
      // New program being loaded: abandon everything.
      state    <= IDLE;
      pc       <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        if_addr  <= pc[ADDR_WIDTH-1:0];
        if_epoch <= epoch;
        pc       <= pc + 1'b1;
      end

      if (state == RUN && redirect) begin
        count <= '0;
      end else begin
        unique case ({push, pop})
          2'b10: begin
            if (count == 2'd0) fifo[0] <= new_entry;
            else               fifo[1] <= new_entry;
            count <= count + 2'd1;
          end
          2'b01: begin
            fifo[0] <= fifo[1];
            count   <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              fifo[0] <= new_entry;
            end else begin
              fifo[0] <= fifo[1];
              fifo[1] <= new_entry;
            end
          end
          default: ;
        endcase
      end

      unique case (state)
        IDLE: if (start) begin
          state <= RUN;
          pc    <= '0;
        end
        RUN: begin
          if (redirect) begin
            epoch <= ~epoch;
            pc    <= {1'b0, redirect_addr};
          end else if (!pc_in_range && count == 2'd0 && !inflight) begin
            state <= DONE;
          end
        end
        DONE: if (start) begin
          state <= RUN;
          pc    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_addr = pc[ADDR_WIDTH-1:0];
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = fifo[0].data;
  assign bus.instr_addr  = fifo[0].addr;
  assign busy            = (state == RUN);
  assign done            = (state == DONE);

endmodule
